// File: rtl/mem_stage_sram_ctrl_if.sv
// Pipeline-side and SRAM control signals of the MEM-stage SRAM controller.
// The controller takes the slave view; the pipeline/bench side takes the master view.
// The bidirectional SRAM data bus stays a plain port on the controller.
interface mem_stage_sram_ctrl_if;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] memory_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        addr_err;

  modport master (
    output mem_r_en, mem_w_en, address, write_data,
    input  memory_data, ready, sram_addr, sram_we_n, sram_oe_n, addr_err
  );

  modport slave (
    input  mem_r_en, mem_w_en, address, write_data,
    output memory_data, ready, sram_addr, sram_we_n, sram_oe_n, addr_err
  );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller: one 32-bit load/store becomes two 16-bit SRAM accesses.
// Latency: ready low for 2*WAIT_CYCLES+1 cycles per access (1 cycle for a rejected address).
// Backpressure: ready drops in the request cycle and stays low until DONE, freezing the pipeline.
// Optional feature: define MEM_ADDR_CHECK_EN to reject misaligned/out-of-range addresses via addr_err.
module mem_stage_sram_ctrl #(
  parameter int          WAIT_CYCLES = 5,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_stage_sram_ctrl_if.slave bus,
  inout  wire  [15:0]          sram_dq
);

  localparam int            CW         = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(WAIT_CYCLES - 1);
  // Count value one before the terminal count; only reachable when WAIT_CYCLES > 1.
  localparam logic [CW-1:0] CNT_PRE    = CW'((WAIT_CYCLES > 1) ? (WAIT_CYCLES - 2) : 0);
  // With a single-cycle phase the only cycle is also the hold cycle, so we_n never drops.
  localparam logic          WE_N_ENTRY = (WAIT_CYCLES == 1) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          op_store;
  logic [16:0]   lat_word;
  logic [15:0]   lat_wdata_hi;
  logic [15:0]   lo_buf;
  logic [31:0]   memory_data_r;
  logic [17:0]   sram_addr_r;
  logic          we_n_r;
  logic          oe_n_r;
  logic          dq_en;
  logic [15:0]   dq_dat;
  logic          addr_err_r;

  logic          req;
  logic [31:0]   addr_off;
  logic [16:0]   req_word;
  logic          req_bad;
  logic          last_cnt;

  assign req      = bus.mem_r_en | bus.mem_w_en;
  assign addr_off = bus.address - BASE_ADDR;
  // Word index wraps by truncation; bits [1:0] of the byte offset are dropped.
  assign req_word = addr_off[18:2];
  assign last_cnt = (cnt == CNT_LAST);

`ifdef MEM_ADDR_CHECK_EN
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_off[1:0];
  assign req_bad = (bus.address < BASE_ADDR) ||
                   (bus.address[1:0] != 2'b00) ||
                   (addr_off[31:19] != 13'd0);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_off[31:19], addr_off[1:0]};
  assign req_bad = 1'b0;
`endif

  // Access sequencer: IDLE -> LO -> HI -> DONE, with all SRAM controls registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      op_store      <= 1'b0;
      lat_word      <= '0;
      lat_wdata_hi  <= '0;
      lo_buf        <= '0;
      memory_data_r <= '0;
      sram_addr_r   <= '0;
      we_n_r        <= 1'b1;
      oe_n_r        <= 1'b1;
      dq_en         <= 1'b0;
      dq_dat        <= '0;
      addr_err_r    <= 1'b0;
    end else begin
      addr_err_r <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            // A store wins when both enables are set.
            op_store     <= bus.mem_w_en;
            lat_word     <= req_word;
            lat_wdata_hi <= bus.write_data[31:16];
            cnt          <= '0;
            if (req_bad) begin
              state      <= DONE;
              addr_err_r <= 1'b1;
            end else begin
              state       <= LO;
              sram_addr_r <= {req_word, 1'b0};
              if (bus.mem_w_en) begin
                we_n_r <= WE_N_ENTRY;
                dq_en  <= 1'b1;
                dq_dat <= bus.write_data[15:0];
              end else begin
                oe_n_r <= 1'b0;
              end
            end
          end
        end
        LO: begin
          if (last_cnt) begin
            state       <= HI;
            cnt         <= '0;
            sram_addr_r <= {lat_word, 1'b1};
            if (op_store) begin
              we_n_r <= WE_N_ENTRY;
              dq_dat <= lat_wdata_hi;
            end else begin
              lo_buf <= sram_dq;
            end
          end else begin
            cnt <= cnt + 1'b1;
            // Release we_n for the final cycle of the phase so the address is held past the write.
            if (cnt == CNT_PRE) we_n_r <= 1'b1;
          end
        end
        HI: begin
          if (last_cnt) begin
            state  <= DONE;
            cnt    <= '0;
            we_n_r <= 1'b1;
            oe_n_r <= 1'b1;
            dq_en  <= 1'b0;
            if (!op_store) memory_data_r <= {sram_dq, lo_buf};
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_PRE) we_n_r <= 1'b1;
          end
        end
        DONE: begin
          // The stalled instruction is still presented here; do not re-sample it.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sram_dq         = dq_en ? dq_dat : 16'bz;
  assign bus.ready       = ((state == IDLE) & ~req) | (state == DONE);
  assign bus.memory_data = memory_data_r;
  assign bus.sram_addr   = sram_addr_r;
  assign bus.sram_we_n   = we_n_r;
  assign bus.sram_oe_n   = oe_n_r;
  assign bus.addr_err    = addr_err_r;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl with WAIT_CYCLES=2, BASE_ADDR=1024.
// A 16-bit SRAM model sits on the data bus; a 32-bit word-level reference predicts results.
// Honours MEM_ADDR_CHECK_EN for the bad-address scenario.
module tb_mem_stage_sram_ctrl;
  localparam int          W    = 2;
  localparam logic [31:0] BASE = 32'd1024;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_stage_sram_ctrl_if bus ();
  wire [15:0] sram_dq;

  mem_stage_sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .sram_dq (sram_dq)
  );

  // SRAM model: drives on oe_n, writes on a clock edge while we_n is low.
  logic [15:0] sram_mem [0:1023];
  assign sram_dq = bus.sram_oe_n ? 16'bz : sram_mem[bus.sram_addr[9:0]];
  always @(posedge clock) if (!bus.sram_we_n) sram_mem[bus.sram_addr[9:0]] <= sram_dq;

  int total = 0;
  int bad   = 0;

  // Word-level reference memory and last loaded value.
  logic [31:0] ref_words [int];
  logic [31:0] exp_md = 32'd0;

  logic [17:0] wr_addr_q [$];
  logic [15:0] wr_dat_q [$];
  logic [17:0] act_addr_q [$];

  function automatic logic [16:0] word_of(input logic [31:0] a);
    int unsigned off;
    off = (a - BASE) / 4;
    return 17'(off % 131072);
  endfunction

  function automatic logic is_bad(input logic [31:0] a);
`ifdef MEM_ADDR_CHECK_EN
    return (a < BASE) || (a % 4 != 0) || (((a - BASE) / 4) >= 131072);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_read(input logic [16:0] w);
    if (ref_words.exists(int'(w))) return ref_words[int'(w)];
    return 32'd0;
  endfunction

  // Present one request and observe it until ready returns (DONE), bounded by a cycle budget.
  task automatic do_op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic scramble, output int rl, output int wel, output int oel,
                       output int errc, output logic [31:0] md, output logic timed_out);
    wr_addr_q.delete(); wr_dat_q.delete(); act_addr_q.delete();
    rl = 0; wel = 0; oel = 0; errc = 0; md = 'x; timed_out = 1'b1;
    @(negedge clock);
    bus.mem_r_en = r; bus.mem_w_en = w; bus.address = a; bus.write_data = d;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!bus.ready) rl++;
      if (!bus.sram_we_n) begin
        wel++;
        wr_addr_q.push_back(bus.sram_addr);
        wr_dat_q.push_back(sram_dq);
      end
      if (!bus.sram_oe_n) oel++;
      if (!bus.sram_we_n || !bus.sram_oe_n) act_addr_q.push_back(bus.sram_addr);
      if (bus.addr_err) errc++;
      if (bus.ready && c > 0) begin
        md = bus.memory_data;
        timed_out = 1'b0;
        break;
      end
      @(negedge clock);
      if (scramble) begin
        bus.address    = $urandom;
        bus.write_data = $urandom;
      end
    end
  endtask

  task automatic go_idle();
    @(negedge clock);
    bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
  endtask

  task automatic test_reset();
    bus.mem_r_en = 0; bus.mem_w_en = 0; bus.address = 0; bus.write_data = 0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
    total++; if (bus.memory_data !== 32'd0) begin bad++; $display("FAIL reset_md: got %h want 0", bus.memory_data); end
    total++; if (bus.sram_addr !== 18'd0) begin bad++; $display("FAIL reset_addr: got %h want 0", bus.sram_addr); end
    total++; if (bus.sram_we_n !== 1'b1 || bus.sram_oe_n !== 1'b1) begin
      bad++; $display("FAIL reset_ctl: we_n=%b oe_n=%b want 1 1", bus.sram_we_n, bus.sram_oe_n); end
    total++; if (bus.addr_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.addr_err); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock); #1;
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", bus.ready); end
  endtask

  task automatic test_reset_mid_hi();
    logic [31:0] a;
    logic [16:0] wd;
    a  = BASE + 32'(4 * 500);
    wd = word_of(a);
    @(negedge clock);
    bus.mem_r_en = 0; bus.mem_w_en = 1; bus.address = a; bus.write_data = $urandom;
    repeat (W + 1) @(negedge clock);
    #1;
    total++; if (bus.sram_we_n !== 1'b0 || bus.sram_addr !== {wd, 1'b1}) begin
      bad++; $display("FAIL midhi_pre: we_n=%b addr=%h want 0 %h", bus.sram_we_n, bus.sram_addr, {wd, 1'b1}); end
    reset = 1'b0;
    #1;
    total++; if (bus.sram_we_n !== 1'b1 || bus.sram_oe_n !== 1'b1) begin
      bad++; $display("FAIL midhi_abort: we_n=%b oe_n=%b want 1 1", bus.sram_we_n, bus.sram_oe_n); end
    bus.mem_w_en = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    exp_md = 32'd0;
    #1;
    total++; if (bus.ready !== 1'b1 || bus.memory_data !== 32'd0) begin
      bad++; $display("FAIL midhi_after: ready=%b md=%h want 1 0", bus.ready, bus.memory_data); end
    @(negedge clock); #1;
    total++; if (bus.ready !== 1'b1 || bus.sram_we_n !== 1'b1 || bus.sram_oe_n !== 1'b1) begin
      bad++; $display("FAIL midhi_idle: ready=%b we_n=%b oe_n=%b want 1 1 1", bus.ready, bus.sram_we_n, bus.sram_oe_n); end
  endtask

  task automatic test_store();
    int rl, wel, oel, errc; logic [31:0] md; logic to;
    do_op(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0, rl, wel, oel, errc, md, to);
    total++; if (to) begin bad++; $display("FAIL store_timeout: got timeout want done"); end
    total++; if (rl !== 2 * W + 1) begin bad++; $display("FAIL store_ready_low: got %0d want %0d", rl, 2 * W + 1); end
    total++; if (wel !== 2 * (W - 1) || oel !== 0) begin
      bad++; $display("FAIL store_strobes: we %0d oe %0d want %0d 0", wel, oel, 2 * (W - 1)); end
    total++; if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 18'd4 || wr_dat_q[0] !== 16'hBEEF
                 || wr_addr_q[1] !== 18'd5 || wr_dat_q[1] !== 16'hDEAD) begin
      bad++; $display("FAIL store_writes: n=%0d first=%h:%h want 4:beef then 5:dead",
                      wr_addr_q.size(), wr_addr_q.size() > 0 ? wr_addr_q[0] : 18'h0,
                      wr_dat_q.size() > 0 ? wr_dat_q[0] : 16'h0); end
    total++; if (md !== exp_md) begin bad++; $display("FAIL store_md: got %h want %h", md, exp_md); end
    ref_words[int'(word_of(32'd1032))] = 32'hDEADBEEF;
    go_idle();
  endtask

  task automatic test_load();
    int rl, wel, oel, errc; logic [31:0] md; logic to;
    do_op(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, rl, wel, oel, errc, md, to);
    exp_md = ref_read(word_of(32'd1032));
    total++; if (to) begin bad++; $display("FAIL load_timeout: got timeout want done"); end
    total++; if (md !== exp_md) begin bad++; $display("FAIL load_md: got %h want %h", md, exp_md); end
    total++; if (oel !== 2 * W || wel !== 0) begin bad++; $display("FAIL load_strobes: oe %0d we %0d want %0d 0", oel, wel, 2 * W); end
    total++; if (rl !== 2 * W + 1) begin bad++; $display("FAIL load_ready_low: got %0d want %0d", rl, 2 * W + 1); end
    go_idle();
  endtask

  task automatic test_both_enables();
    int rl, wel, oel, errc; logic [31:0] md; logic to; logic [31:0] a; logic [16:0] wd;
    a  = BASE + 32'(4 * $urandom_range(10, 20));
    wd = word_of(a);
    do_op(1'b1, 1'b1, a, 32'h12345678, 1'b0, rl, wel, oel, errc, md, to);
    total++; if (to || oel !== 0 || wel !== 2 * (W - 1)) begin
      bad++; $display("FAIL both_strobes: to=%b oe %0d we %0d want 0 0 %0d", to, oel, wel, 2 * (W - 1)); end
    total++; if (wr_addr_q.size() != 2 || wr_addr_q[0] !== {wd, 1'b0} || wr_dat_q[0] !== 16'h5678
                 || wr_addr_q[1] !== {wd, 1'b1} || wr_dat_q[1] !== 16'h1234) begin
      bad++; $display("FAIL both_writes: n=%0d want 2 writes of 5678/1234 at %h", wr_addr_q.size(), {wd, 1'b0}); end
    total++; if (md !== exp_md) begin bad++; $display("FAIL both_md_kept: got %h want %h", md, exp_md); end
    ref_words[int'(wd)] = 32'h12345678;
    do_op(1'b1, 1'b0, a, 32'h0, 1'b0, rl, wel, oel, errc, md, to);
    exp_md = ref_read(wd);
    total++; if (md !== exp_md) begin bad++; $display("FAIL both_readback: got %h want %h", md, exp_md); end
    go_idle();
  endtask

  task automatic test_back_to_back();
    int rl, wel, oel, errc; logic [31:0] md; logic to; logic [31:0] d0, d1;
    d0 = $urandom; d1 = $urandom;
    do_op(1'b0, 1'b1, 32'd1024, d0, 1'b1, rl, wel, oel, errc, md, to);
    ref_words[int'(word_of(32'd1024))] = d0;
    do_op(1'b0, 1'b1, 32'd1028, d1, 1'b1, rl, wel, oel, errc, md, to);
    ref_words[int'(word_of(32'd1028))] = d1;
    do_op(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1, rl, wel, oel, errc, md, to);
    exp_md = ref_read(word_of(32'd1024));
    total++; if (to || rl !== 2 * W + 1) begin bad++; $display("FAIL b2b_first_ready_low: got %0d want %0d", rl, 2 * W + 1); end
    total++; if (md !== exp_md) begin bad++; $display("FAIL b2b_first_md: got %h want %h", md, exp_md); end
    do_op(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, rl, wel, oel, errc, md, to);
    exp_md = ref_read(word_of(32'd1028));
    total++; if (to || rl !== 2 * W + 1) begin bad++; $display("FAIL b2b_second_ready_low: got %0d want %0d", rl, 2 * W + 1); end
    total++; if (md !== exp_md) begin bad++; $display("FAIL b2b_second_md: got %h want %h", md, exp_md); end
    go_idle();
    #1;
    total++; if (bus.ready !== 1'b1 || bus.sram_oe_n !== 1'b1) begin
      bad++; $display("FAIL b2b_no_dup: ready=%b oe_n=%b want 1 1", bus.ready, bus.sram_oe_n); end
  endtask

  task automatic test_bad_addr();
    int rl, wel, oel, errc; logic [31:0] md; logic to;
    do_op(1'b1, 1'b0, 32'd1026, 32'h0, 1'b0, rl, wel, oel, errc, md, to);
`ifdef MEM_ADDR_CHECK_EN
    total++; if (to || rl !== 1) begin bad++; $display("FAIL bad_ready_low: got %0d want 1", rl); end
    total++; if (errc !== 1) begin bad++; $display("FAIL bad_err_pulse: got %0d want 1", errc); end
    total++; if (wel !== 0 || oel !== 0) begin bad++; $display("FAIL bad_strobes: we %0d oe %0d want 0 0", wel, oel); end
    total++; if (md !== exp_md) begin bad++; $display("FAIL bad_md: got %h want %h", md, exp_md); end
    go_idle();
    #1;
    total++; if (bus.addr_err !== 1'b0) begin bad++; $display("FAIL bad_err_clear: got %b want 0", bus.addr_err); end
`else
    exp_md = ref_read(word_of(32'd1026));
    total++; if (to || rl !== 2 * W + 1 || errc !== 0) begin
      bad++; $display("FAIL unaligned_timing: ready_low %0d err %0d want %0d 0", rl, errc, 2 * W + 1); end
    total++; if (act_addr_q.size() != 2 * W || act_addr_q[0] !== 18'd0 || act_addr_q[2 * W - 1] !== 18'd1) begin
      bad++; $display("FAIL unaligned_addr: n=%0d want %0d accesses at 0 then 1", act_addr_q.size(), 2 * W); end
    total++; if (md !== exp_md) begin bad++; $display("FAIL unaligned_md: got %h want %h", md, exp_md); end
    go_idle();
`endif
  endtask

  task automatic test_random();
    int rl, wel, oel, errc; logic [31:0] md; logic to;
    logic [31:0] a, d; logic r, w, st, bd; logic [16:0] wd; int k;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 2);
      r = (k != 1); w = (k != 0); st = w;
      a = BASE + 32'(4 * $urandom_range(0, 255));
`ifdef MEM_ADDR_CHECK_EN
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
`else
      a = a + 32'($urandom_range(0, 3));
`endif
      d  = $urandom;
      wd = word_of(a);
      bd = is_bad(a);
      do_op(r, w, a, d, 1'($urandom_range(0, 1)), rl, wel, oel, errc, md, to);
      if (!bd && !st) exp_md = ref_read(wd);
      total++; if (to || rl !== (bd ? 1 : 2 * W + 1)) begin
        bad++; $display("FAIL rand_ready_low[%0d]: got %0d want %0d", i, rl, bd ? 1 : 2 * W + 1); end
      total++; if (wel !== ((st && !bd) ? 2 * (W - 1) : 0) || oel !== ((!st && !bd) ? 2 * W : 0)) begin
        bad++; $display("FAIL rand_strobes[%0d]: we %0d oe %0d", i, wel, oel); end
      total++; if (errc !== (bd ? 1 : 0)) begin bad++; $display("FAIL rand_err[%0d]: got %0d want %0d", i, errc, bd ? 1 : 0); end
      total++; if (md !== exp_md) begin bad++; $display("FAIL rand_md[%0d]: got %h want %h", i, md, exp_md); end
      if (st && !bd && wr_addr_q.size() == 2 * (W - 1)) begin
        for (int j = 0; j < 2 * (W - 1); j++) begin
          total++;
          if (wr_addr_q[j] !== {wd, 1'(j >= W - 1)} || wr_dat_q[j] !== ((j >= W - 1) ? d[31:16] : d[15:0])) begin
            bad++; $display("FAIL rand_write[%0d.%0d]: got %h:%h", i, j, wr_addr_q[j], wr_dat_q[j]);
          end
        end
      end
      if (st && !bd) ref_words[int'(wd)] = d;
      if ($urandom_range(0, 1) == 1) go_idle();
    end
    go_idle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) sram_mem[i] = 16'h0;
    test_reset();
    test_reset_mid_hi();
    test_store();
    test_load();
    test_both_enables();
    test_back_to_back();
    test_bad_addr();
    test_random();
    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
